// File: rtl/regfile_sweep.sv
// regfile_sweep
//   General-purpose register file for the single-cycle CPU datapath.
//   Two combinational read ports, one synchronous write port, and a
//   destination mux selecting rt / rd / link register. Reset does not clear
//   storage at once. It starts a sweep that zeroes one entry per clock and
//   holds `ready` low until every entry is zero.
//
//   Optional feature: define REGFILE_BYPASS_EN to forward `write_data` to a
//   read port in the same cycle when that port's address matches the
//   qualified write address.
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous active-high; (re)starts the clear sweep
//   rs, rt      read addresses (rt is also the write target for dst_sel=00)
//   rd          write target for dst_sel=01
//   dst_sel     00 rt, 01 rd, 10 LINK_REG, 11 no write
//   RegWre      write enable
//   write_data  value to store
//   readData1   contents of entry rs (0 while not usable)
//   readData2   contents of entry rt (0 while not usable)
//   ready       high once the sweep has finished and the file is usable
module regfile_sweep #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int LINK_REG = (2**ADDR_W) - 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    input  logic [ADDR_W-1:0] rd,
    input  logic [1:0]        dst_sel,
    input  logic              RegWre,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] readData1,
    output logic [DATA_W-1:0] readData2,
    output logic              ready
);
    localparam int DEPTH = 2**ADDR_W;

    typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] cnt, cnt_nxt;
    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] waddr;
    logic              usable;
    logic              wr_q;

    // ---------------- sweep FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            CLEAR: begin
                cnt_nxt = cnt + ADDR_W'(1);
                if (cnt == ADDR_W'(DEPTH - 1))
                    state_nxt = RUN;
            end
            RUN: ;
            default: state_nxt = CLEAR;
        endcase
    end

    // The file is only usable in RUN with reset released; a reset edge that
    // lands while in RUN must not also perform a write or expose data.
    assign usable = (state == RUN) && !reset;
    assign ready  = usable;

    // ---------------- write path ----------------
    always_comb begin
        case (dst_sel)
            2'b00:   waddr = rt;
            2'b01:   waddr = rd;
            2'b10:   waddr = ADDR_W'(LINK_REG);
            default: waddr = '0;
        endcase
    end

    assign wr_q = usable && RegWre && (dst_sel != 2'b11) &&
                  !((ZERO_REG != 0) && (waddr == '0));

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == CLEAR)
                mem[cnt] <= '0;
            else if (wr_q)
                mem[waddr] <= write_data;
        end
    end

    // ---------------- read path ----------------
    always_comb begin
        readData1 = '0;
        readData2 = '0;
        if (usable) begin
            if (!((ZERO_REG != 0) && (rs == '0)))
                readData1 = mem[rs];
            if (!((ZERO_REG != 0) && (rt == '0)))
                readData2 = mem[rt];
`ifdef REGFILE_BYPASS_EN
            // wr_q already excludes a protected entry 0, so forwarding here
            // can never make entry 0 read nonzero.
            if (wr_q && (waddr == rs))
                readData1 = write_data;
            if (wr_q && (waddr == rt))
                readData2 = write_data;
`endif
        end
    end

endmodule

// File: tb/tb_regfile_sweep.sv
// Directed bench for regfile_sweep (default parameters).
module tb_regfile_sweep;
    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rs, rt, rd;
    logic [1:0]  dst_sel;
    logic        RegWre;
    logic [31:0] write_data;
    logic [31:0] readData1, readData2;
    logic        ready;

    int pass_cnt = 0;
    int total    = 0;

    regfile_sweep dut (
        .clk(clk), .reset(reset), .rs(rs), .rt(rt), .rd(rd),
        .dst_sel(dst_sel), .RegWre(RegWre), .write_data(write_data),
        .readData1(readData1), .readData2(readData2), .ready(ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  dsel;
        logic [4:0]  rs, rt, rd;
        logic [31:0] wdata;
        logic [31:0] exp1, exp2;
    } vec_t;

    vec_t vt [14];

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    // inputs change 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sweep_and_check(input string tag, input bit wr_during);
        for (int e = 1; e <= 32; e++) begin
            RegWre     = wr_during;
            dst_sel    = 2'b01;
            rd         = 5'((e + 30) % 32);
            rs         = rd;
            write_data = 32'hFFFF_0000 | 32'(e);
            #1;
            chk($sformatf("%s_rd1_clear_e%0d", tag, e), readData1, 32'h0);
            tick();
            chk($sformatf("%s_ready_e%0d", tag, e), {31'b0, ready}, {31'b0, (e == 32)});
        end
        RegWre = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rs = 5'(i);
            rt = 5'(31 - i);
            #1;
            chk($sformatf("%s_zero_rs%0d", tag, i), readData1, 32'h0);
            chk($sformatf("%s_zero_rt%0d", tag, 31 - i), readData2, 32'h0);
        end
    endtask

    initial begin
        // Expected values are read-port values sampled before the edge
        // that applies the vector's write.
        vt[0]  = '{1, 2'b01, 5'd5,  5'd0,  5'd5, 32'hDEADBEEF, BYP ? 32'hDEADBEEF : 32'h0, 32'h0};
        vt[1]  = '{0, 2'b01, 5'd5,  5'd5,  5'd0, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF};
        vt[2]  = '{1, 2'b00, 5'd5,  5'd7,  5'd0, 32'h00000012, 32'hDEADBEEF, BYP ? 32'h12 : 32'h0};
        vt[3]  = '{0, 2'b00, 5'd7,  5'd31, 5'd0, 32'h0,        32'h00000012, 32'h0};
        vt[4]  = '{1, 2'b10, 5'd31, 5'd7,  5'd5, 32'h00400004, BYP ? 32'h00400004 : 32'h0, 32'h12};
        vt[5]  = '{0, 2'b10, 5'd31, 5'd5,  5'd0, 32'h0,        32'h00400004, 32'hDEADBEEF};
        vt[6]  = '{1, 2'b11, 5'd31, 5'd7,  5'd5, 32'hCAFEF00D, 32'h00400004, 32'h12};
        vt[7]  = '{0, 2'b11, 5'd5,  5'd7,  5'd0, 32'h0,        32'hDEADBEEF, 32'h12};
        vt[8]  = '{1, 2'b01, 5'd0,  5'd0,  5'd0, 32'hFFFFFFFF, 32'h0, 32'h0};
        vt[9]  = '{1, 2'b00, 5'd0,  5'd0,  5'd9, 32'hFFFFFFFF, 32'h0, 32'h0};
        vt[10] = '{1, 2'b01, 5'd3,  5'd5,  5'd3, 32'hA5A5A5A5, BYP ? 32'hA5A5A5A5 : 32'h0, 32'hDEADBEEF};
        vt[11] = '{0, 2'b01, 5'd3,  5'd31, 5'd0, 32'h0,        32'hA5A5A5A5, 32'h00400004};
        vt[12] = '{0, 2'b01, 5'd3,  5'd3,  5'd3, 32'h11111111, 32'hA5A5A5A5, 32'hA5A5A5A5};
        vt[13] = '{0, 2'b01, 5'd0,  5'd7,  5'd3, 32'h0,        32'h0, 32'h12};

        // ---- reset, with a write attempt on the reset edge ----
        reset = 1'b1; RegWre = 1'b1; dst_sel = 2'b01; rd = 5'd4; rs = 5'd4; rt = 5'd4;
        write_data = 32'hFFFF_FFFF;
        tick();
        chk("reset_ready", {31'b0, ready}, 32'h0);
        chk("reset_rd1", readData1, 32'h0);
        chk("reset_rd2", readData2, 32'h0);
        reset = 1'b0;

        // ---- first sweep, RegWre held high during CLEAR ----
        sweep_and_check("sw1", 1'b1);

        // ---- table-driven RUN vectors ----
        for (int v = 0; v < 14; v++) begin
            RegWre = vt[v].we; dst_sel = vt[v].dsel;
            rs = vt[v].rs; rt = vt[v].rt; rd = vt[v].rd; write_data = vt[v].wdata;
            #1;
            chk($sformatf("vec%0d_ready", v), {31'b0, ready}, 32'h1);
            chk($sformatf("vec%0d_rd1", v), readData1, vt[v].exp1);
            chk($sformatf("vec%0d_rd2", v), readData2, vt[v].exp2);
            tick();
        end
        RegWre = 1'b0;

        // ---- fill all entries, then abort a sweep mid-way ----
        for (int i = 1; i < 32; i++) begin
            RegWre = 1'b1; dst_sel = 2'b01; rd = 5'(i); write_data = 32'h1000_0000 + 32'(i);
            tick();
        end
        RegWre = 1'b0; rs = 5'd20; rt = 5'd31;
        #1;
        chk("fill_rd1", readData1, 32'h1000_0014);
        chk("fill_rd2", readData2, 32'h1000_001F);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        rs = 5'd20;
        #1;
        chk("clear_rd1_forced0", readData1, 32'h0);
        for (int c = 0; c < 10; c++) tick();
        chk("midsweep_ready", {31'b0, ready}, 32'h0);
        reset = 1'b1;
        tick();
        chk("rereset_ready", {31'b0, ready}, 32'h0);
        reset = 1'b0;

        sweep_and_check("sw2", 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
